i2s_tx_serializer: RTL and testbench



---
 rtl/i2s_tx_serializer_pkg.sv | 18 +
 rtl/i2s_tx_serializer_if.sv | 13 +
 rtl/i2s_tx_sclk_gen.sv | 36 +++
 rtl/i2s_tx_serializer.sv | 111 +++++++++++
 tb/tb_i2s_tx_serializer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/i2s_tx_serializer_pkg.sv
// i2s_tx_serializer_pkg: shared types, constants and bit-select helper for the I2S transmit serializer
package i2s_tx_serializer_pkg;
  localparam int I2S_BITS_PER_CHANNEL = 32;
  localparam int I2S_SAMPLE_MSB = 27;
  localparam int I2S_SAMPLE_BITS = 24;
  typedef logic [31:0] axi_stream_data;
  typedef logic [2:0] axi_stream_tid;
  typedef enum logic [1:0] {IDLE, ARM, RUN} i2s_tx_state_e;
  // Slots always hold tdata[27:4]; a 16-bit sample is the top 16 bits of that field,
  // so channel bit b maps to slot bit 24-b for both word lengths.
  function automatic logic i2s_bit(input logic [4:0] b, input logic [I2S_SAMPLE_BITS-1:0] s, input logic w24);
    logic [31:0] ext;
    logic [4:0] idx;
    ext = 32'(s);
    idx = 5'd24 - b;
    return (b != 5'd0) && (b <= (w24 ? 5'd24 : 5'd16)) && ext[idx];
  endfunction
endpackage

// File: rtl/i2s_tx_serializer_if.sv
// i2s_tx_serializer_if: AXI4-Stream audio sample channel
// master drives tdata/tid/tvalid and samples tready; slave is the reverse.
interface i2s_tx_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TID_WIDTH  = 3
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [TID_WIDTH-1:0]  tid;
  logic                  tvalid;
  logic                  tready;
  modport master (output tdata, tid, tvalid, input tready);
  modport slave  (input tdata, tid, tvalid, output tready);
endinterface

// File: rtl/i2s_tx_sclk_gen.sv
// i2s_tx_sclk_gen: programmable SCLK divider with one-cycle edge strobes
// aud_mclk/aud_mrst_n: clock and sync active-low reset; run_i: count enable (held low, sclk low, when 0)
// div_i: half-period in aud_mclk cycles (0 behaves as 1); sclk_o: serial clock
// sclk_fall_o/sclk_rise_o: high in the cycle whose edge drives sclk_o 1->0 / 0->1
module i2s_tx_sclk_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 aud_mclk,
  input  logic                 aud_mrst_n,
  input  logic                 run_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 sclk_o,
  output logic                 sclk_fall_o,
  output logic                 sclk_rise_o
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, last;
  logic sclk_q, sclk_d, tc;
  always_comb begin
    last   = (div_i == '0) ? '0 : div_i - 1'b1;
    tc     = run_i && (cnt_q == last);
    cnt_d  = (!run_i || tc) ? '0 : cnt_q + 1'b1;
    sclk_d = run_i && (tc ? ~sclk_q : sclk_q);
  end
  always_ff @(posedge aud_mclk) begin
    if (!aud_mrst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
  assign sclk_o      = sclk_q;
  assign sclk_fall_o = tc && sclk_q;
  assign sclk_rise_o = tc && !sclk_q;
endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: buffers one stereo pair from AXI-Stream and shifts it out in I2S (Philips) format
// aud_mclk/aud_mrst_n: clock and sync active-low reset; enable: core enable
// word_len24: 1 = 24-bit (tdata[27:4]), 0 = 16-bit (tdata[27:12]); sclk_div: SCLK half-period
// s_axis_aud: sample stream (tid 0 left, 1 right, others dropped)
// sclk_out/lrclk_out/sdata_out: I2S pins; underflow: frame started with an empty slot; busy: ARM or RUN
module i2s_tx_serializer
  import i2s_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TID_WIDTH  = 3,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                 aud_mclk,
  input  logic                 aud_mrst_n,
  input  logic                 enable,
  input  logic                 word_len24,
  input  logic [DIV_WIDTH-1:0] sclk_div,
  i2s_tx_serializer_if.slave   s_axis_aud,
  output logic                 sclk_out,
  output logic                 lrclk_out,
  output logic                 sdata_out,
  output logic                 underflow,
  output logic                 busy
);
  i2s_tx_state_e state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [5:0] bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [I2S_SAMPLE_BITS-1:0] l_q, l_d, r_q, r_d, l_sh_q, l_sh_d, r_sh_q, r_sh_d, sample;
  logic l_full_q, l_full_d, r_full_q, r_full_d, w24_q, w24_d;
  logic sdata_q, sdata_d, uf_q, uf_d, stop_q, stop_d;
  logic run, fall, boundary, stopping, latch, tid_l, tid_r, tready, acc_l, acc_r;
  logic unused_sclk_rise, unused_tdata;
  i2s_tx_sclk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_sclk (
    .aud_mclk   (aud_mclk),
    .aud_mrst_n (aud_mrst_n),
    .run_i      (run),
    .div_i      (div_q),
    .sclk_o     (sclk_out),
    .sclk_fall_o(fall),
    .sclk_rise_o(unused_sclk_rise)
  );
  assign unused_tdata = ^{s_axis_aud.tdata[DATA_WIDTH-1:I2S_SAMPLE_MSB+1],
                          s_axis_aud.tdata[I2S_SAMPLE_MSB-I2S_SAMPLE_BITS:0]};
  always_comb begin
    run      = state_q == RUN;
    boundary = fall && (bit_cnt_q == 6'd63);
    // once a disable is seen in RUN the current frame still finishes
    stopping = stop_q || !enable;
    latch    = (state_q == ARM && enable && l_full_q && r_full_q) || (boundary && !stopping);
    tid_l    = s_axis_aud.tid == TID_WIDTH'(0);
    tid_r    = s_axis_aud.tid == TID_WIDTH'(1);
    // a slot being latched this cycle counts as free, so a waiting sample lands in it
    tready   = enable && ((tid_l && (!l_full_q || latch)) || (tid_r && (!r_full_q || latch)) || (!tid_l && !tid_r));
    acc_l    = s_axis_aud.tvalid && tready && tid_l;
    acc_r    = s_axis_aud.tvalid && tready && tid_r;
    sample   = s_axis_aud.tdata[I2S_SAMPLE_MSB -: I2S_SAMPLE_BITS];
    state_d  = (state_q == IDLE) ? (enable ? ARM : IDLE)
             : (state_q == ARM)  ? (!enable ? IDLE : (l_full_q && r_full_q) ? RUN : ARM)
             : (boundary && stopping) ? IDLE : RUN;
    l_full_d = acc_l || (l_full_q && !latch);
    r_full_d = acc_r || (r_full_q && !latch);
    l_d      = acc_l ? sample : l_q;
    r_d      = acc_r ? sample : r_q;
    l_sh_d   = latch ? (l_full_q ? l_q : '0) : l_sh_q;
    r_sh_d   = latch ? (r_full_q ? r_q : '0) : r_sh_q;
    w24_d    = latch ? word_len24 : w24_q;
    div_d    = (state_q == IDLE && enable) ? sclk_div : div_q;
    bit_nxt  = bit_cnt_q + 6'd1;
    bit_cnt_d = !run ? '0 : fall ? bit_nxt : bit_cnt_q;
    // data is registered alongside bit_cnt so both change on the SCLK falling edge
    sdata_d  = !run ? 1'b0 : fall ? i2s_bit(bit_nxt[4:0], bit_nxt[5] ? r_sh_q : l_sh_q, w24_q) : sdata_q;
    uf_d     = boundary && !stopping && !(l_full_q && r_full_q);
    stop_d   = run && stopping;
  end
  always_ff @(posedge aud_mclk) begin
    if (!aud_mrst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      l_q       <= '0;
      r_q       <= '0;
      l_sh_q    <= '0;
      r_sh_q    <= '0;
      l_full_q  <= 1'b0;
      r_full_q  <= 1'b0;
      w24_q     <= 1'b0;
      sdata_q   <= 1'b0;
      uf_q      <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      l_q       <= l_d;
      r_q       <= r_d;
      l_sh_q    <= l_sh_d;
      r_sh_q    <= r_sh_d;
      l_full_q  <= l_full_d;
      r_full_q  <= r_full_d;
      w24_q     <= w24_d;
      sdata_q   <= sdata_d;
      uf_q      <= uf_d;
      stop_q    <= stop_d;
    end
  end
  assign s_axis_aud.tready = tready;
  assign lrclk_out = bit_cnt_q[5];
  assign sdata_out = sdata_q;
  assign underflow = uf_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: directed self-checking bench for the I2S transmit serializer
`timescale 1ns/1ps
module tb_i2s_tx_serializer;
  import i2s_tx_serializer_pkg::*;
  logic aud_mclk = 1'b0;
  logic aud_mrst_n, enable, word_len24;
  logic [7:0] sclk_div;
  logic sclk_out, lrclk_out, sdata_out, underflow, busy;
  int n_cmp = 0, n_bad = 0, rc = 0, acc_cnt = 0, acc_uf = 0, uf_cnt = 0;
  logic sclk_prev = 1'b0, last_acc = 1'b0;
  logic sd_rec [0:1023];
  logic lr_rec [0:1023];
  longint rise_t [0:1023];

  i2s_tx_serializer_if #(.DATA_WIDTH(32), .TID_WIDTH(3)) s_if ();

  i2s_tx_serializer #(.DATA_WIDTH(32), .TID_WIDTH(3), .DIV_WIDTH(8)) dut (
    .aud_mclk  (aud_mclk),
    .aud_mrst_n(aud_mrst_n),
    .enable    (enable),
    .word_len24(word_len24),
    .sclk_div  (sclk_div),
    .s_axis_aud(s_if),
    .sclk_out  (sclk_out),
    .lrclk_out (lrclk_out),
    .sdata_out (sdata_out),
    .underflow (underflow),
    .busy      (busy)
  );

  always #5 aud_mclk = ~aud_mclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one aud_mclk cycle; handshake judged mid-cycle, outputs sampled 1ns after the edge,
  // and every SCLK rising edge records what a receiver would capture
  task automatic tick();
    logic a;
    @(negedge aud_mclk);
    a = s_if.tvalid && s_if.tready;
    @(posedge aud_mclk);
    #1;
    if (a) acc_cnt++;
    if (a && underflow) acc_uf++;
    if (underflow) uf_cnt++;
    if (sclk_out && !sclk_prev && rc < 1024) begin
      sd_rec[rc] = sdata_out;
      lr_rec[rc] = lrclk_out;
      rise_t[rc] = longint'($time);
      rc++;
    end
    sclk_prev = sclk_out;
    last_acc = a;
  endtask

  task automatic send(input axi_stream_tid id, input axi_stream_data d);
    int n;
    n = 0;
    s_if.tid = id;
    s_if.tdata = d;
    s_if.tvalid = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 3000);
    s_if.tvalid = 1'b0;
    chk("send_accepted", 64'(last_acc), 64'd1);
  endtask

  task automatic wait_rc(input int target);
    int n;
    n = 0;
    while (rc < target && n < 5000) begin
      tick();
      n++;
    end
    chk("sclk_rises_reached", 64'(rc >= target), 64'd1);
  endtask

  function automatic logic [31:0] word_at(input int s, input bit lr);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[31-i] = lr ? lr_rec[s+i] : sd_rec[s+i];
    return w;
  endfunction

  initial begin
    int n;
    aud_mrst_n = 1'b0;
    enable = 1'b0;
    word_len24 = 1'b1;
    sclk_div = 8'd2;
    s_if.tvalid = 1'b0;
    s_if.tid = '0;
    s_if.tdata = '0;
    repeat (3) tick();
    chk("rst_sclk", 64'(sclk_out), 64'd0);
    chk("rst_lrclk", 64'(lrclk_out), 64'd0);
    chk("rst_sdata", 64'(sdata_out), 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    aud_mrst_n = 1'b1;
    rc = 0;
    enable = 1'b1;
    tick();
    chk("arm_busy", 64'(busy), 64'd1);
    send(3'd0, 32'h0A5A_5A50);
    send(3'd1, 32'h05A5_A5A0);
    send(3'd0, 32'h0ABC_D000);
    send(3'd1, 32'h0123_4000);
    word_len24 = 1'b0;
    send(3'd5, 32'h0FFF_FFF0);
    send(3'd0, 32'h0800_1000);
    wait_rc(130);
    chk("underflow_one_cycle", 64'(uf_cnt), 64'd1);
    acc_cnt = 0;
    s_if.tid = 3'd0;
    s_if.tdata = 32'h0FFF_F000;
    s_if.tvalid = 1'b1;
    repeat (5) tick();
    chk("bp_first_accept", 64'(acc_cnt), 64'd1);
    chk("bp_tready_low", 64'(s_if.tready), 64'd0);
    wait_rc(260);
    s_if.tvalid = 1'b0;
    chk("bp_one_per_frame", 64'(acc_cnt), 64'd3);
    chk("bp_accept_at_boundary", 64'(acc_uf), 64'd2);
    chk("underflow_count", 64'(uf_cnt), 64'd3);
    wait_rc(277);
    enable = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk("dis_busy_fell", 64'(busy), 64'd0);
    chk("dis_frame_completed", 64'(rc), 64'd320);
    repeat (10) tick();
    chk("dis_no_more_sclk", 64'(rc), 64'd320);
    chk("dis_sclk", 64'(sclk_out), 64'd0);
    chk("dis_lrclk", 64'(lrclk_out), 64'd0);
    chk("dis_sdata", 64'(sdata_out), 64'd0);
    chk("dis_no_underflow", 64'(uf_cnt), 64'd3);
    chk("f1_left", 64'(word_at(0, 0)), 64'h52D2_D280);
    chk("f1_right", 64'(word_at(32, 0)), 64'h2D2D_2D00);
    chk("f1_lr_left", 64'(word_at(0, 1)), 64'h0000_0000);
    chk("f1_lr_right", 64'(word_at(32, 1)), 64'hFFFF_FFFF);
    chk("f1_frame_ns", 64'(rise_t[64] - rise_t[0]), 64'd2560);
    chk("f2_left16", 64'(word_at(64, 0)), 64'h55E6_8000);
    chk("f2_right16", 64'(word_at(96, 0)), 64'h091A_0000);
    chk("f3_left", 64'(word_at(128, 0)), 64'h4000_8000);
    chk("f3_right_zero", 64'(word_at(160, 0)), 64'h0000_0000);
    chk("f4_left", 64'(word_at(192, 0)), 64'h7FFF_8000);
    chk("f4_right_zero", 64'(word_at(224, 0)), 64'h0000_0000);
    chk("f5_left", 64'(word_at(256, 0)), 64'h7FFF_8000);
    chk("f5_lr_right", 64'(word_at(288, 1)), 64'hFFFF_FFFF);
    rc = 0;
    enable = 1'b1;
    tick();
    send(3'd1, 32'h0123_4000);
    send(3'd0, 32'h0ABC_D000);
    wait_rc(41);
    s_if.tid = 3'd0;
    #1;
    chk("pre_rst_tready", 64'(s_if.tready), 64'd0);
    chk("pre_rst_lrclk", 64'(lrclk_out), 64'd1);
    aud_mrst_n = 1'b0;
    tick();
    chk("mid_rst_sclk", 64'(sclk_out), 64'd0);
    chk("mid_rst_lrclk", 64'(lrclk_out), 64'd0);
    chk("mid_rst_sdata", 64'(sdata_out), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_slot_empty", 64'(s_if.tready), 64'd1);
    enable = 1'b0;
    tick();
    aud_mrst_n = 1'b1;
    sclk_div = 8'd0;
    word_len24 = 1'b1;
    tick();
    rc = 0;
    enable = 1'b1;
    send(3'd0, 32'h0123_4560);
    send(3'd1, 32'h0FED_CBA0);
    wait_rc(64);
    chk("d0_sclk_period_ns", 64'(rise_t[1] - rise_t[0]), 64'd20);
    chk("d0_left", 64'(word_at(0, 0)), 64'h091A_2B00);
    chk("d0_right", 64'(word_at(32, 0)), 64'h7F6E_5D00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
